imem_loader: RTL and testbench

Instruction-memory loader: the write-side counterpart to the fetch unit. Accepts a byte stream over a valid/ready handshake, packs byte pairs little-endian into 16-bit instructions, and writes them into the fetch unit's instruction memory at consecutive even byte addresses starting at a programmed base. While a load is in progress it holds the fetch unit (pc_en low) so no instruction is fetched from a partially written image.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states and the
// instruction size in bytes.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int INSTR_BYTES = 2;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream little-endian into 16-bit
// words, writes them at consecutive even addresses and holds fetch meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  word_count,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               fetch_hold,
    output logic               done,
    output logic               err,
    output logic [INSTR_W-1:0] checksum
);

    // Size of the address space, one bit wider than an address.
    localparam logic [ADDR_W:0] SPAN = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [7:0]          lo_q, lo_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [INSTR_W-1:0]  checksum_q, checksum_d;
    logic                mem_we_q, mem_we_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [ADDR_W:0]     room;
    logic                too_long;
    logic [INSTR_W-1:0]  word;

    // Words that fit between base_addr and the top of memory without wrapping.
    assign room     = (SPAN - {1'b0, base_addr}) >> 1;
    assign too_long = {1'b0, word_count} > room;
    assign word     = {in_data, lo_q};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        lo_d        = lo_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        checksum_d  = checksum_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    checksum_d  = '0;
                    if (base_addr[0])
                        state_d = ST_ERR;
                    else if (word_count == '0)
                        state_d = ST_DONE;
                    else if (too_long)
                        state_d = ST_ERR;
                    else
                        state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (in_valid) begin
                    lo_d    = in_data;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                // The write-cycle outputs are prepared here so that they are
                // registered and present throughout the WRITE cycle.
                if (in_valid) begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = word;
                    checksum_d  = checksum_q + word;
                    addr_d      = addr_q + ADDR_W'(INSTR_BYTES);
                    remaining_d = remaining_q - ADDR_W'(1);
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = (remaining_q == '0) ? ST_DONE : ST_LO;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are decoded from the next state so they line up with it.
        mem_we_d   = (state_d == ST_WRITE);
        in_ready_d = (state_d == ST_LO) || (state_d == ST_HI);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            lo_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            checksum_q  <= '0;
            mem_we_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            lo_q        <= lo_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            checksum_q  <= checksum_d;
            mem_we_q    <= mem_we_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign fetch_hold = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random loads checked against a
// word-level model of the expected writes, checksum, outcome and timing.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        fetch_hold;
    logic        done;
    logic        err;
    logic [15:0] checksum;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [7:0]  pc = 8'h00;

    logic [7:0]  stim[$];
    logic [23:0] exp_q[$];
    logic [23:0] wr_q[$];

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .fetch_hold (fetch_hold),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // fetch-unit pc stand-in: advances only while not held
    always @(posedge clk) begin
        if (rst) pc <= 8'h00;
        else if (!fetch_hold) pc <= pc + 8'd2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // write monitor and hold/alignment checks, sampled mid-cycle
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_we === 1'b1) begin
                wr_q.push_back({mem_addr, mem_wdata});
                chk("addr_even", {31'd0, mem_addr[0]}, 32'd0);
            end
            chk("hold_eq_busy", {31'd0, fetch_hold}, {31'd0, busy});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input string name);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (in_ready !== 1'b1) chk({name, ":ready_timeout"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic gap_cycle(input string name);
        logic rdy_before;
        in_valid   = 1'b0;
        rdy_before = in_ready;
        @(posedge clk); #1;
        if (rdy_before === 1'b1) chk({name, ":ready_held"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ":in_ready"},  {31'd0, in_ready},   32'd0);
        chk({name, ":mem_we"},    {31'd0, mem_we},     32'd0);
        chk({name, ":busy"},      {31'd0, busy},       32'd0);
        chk({name, ":hold"},      {31'd0, fetch_hold}, 32'd0);
        chk({name, ":done"},      {31'd0, done},       32'd0);
        chk({name, ":err"},       {31'd0, err},        32'd0);
        chk({name, ":mem_addr"},  {24'd0, mem_addr},   32'd0);
        chk({name, ":mem_wdata"}, {16'd0, mem_wdata},  32'd0);
        chk({name, ":checksum"},  {16'd0, checksum},   32'd0);
    endtask

    // Runs one load; bytes come from stim (topped up randomly if short).
    // gap_mode: 0 back-to-back, 1 idle cycle before every byte, 2 random idles.
    task automatic run_load(input logic [7:0] base, input logic [7:0] count,
                            input int gap_mode, input bit restart, input string name);
        bit          exp_err;
        int          n_bytes;
        int          exp_ck;
        int          exp_lat;
        int          c0;
        int          t;
        logic [7:0]  pc0;

        // reference model: outcome, write list and checksum from the load rules
        exp_err = (base[0] == 1'b1) || (int'(count) > (256 - int'(base)) / 2);
        n_bytes = exp_err ? 0 : 2 * int'(count);
        while (stim.size() < n_bytes) stim.push_back(8'($urandom));
        exp_q.delete();
        exp_ck = 0;
        for (int i = 0; i < n_bytes / 2; i++) begin
            exp_q.push_back({8'(int'(base) + 2 * i), stim[2*i+1], stim[2*i]});
            exp_ck = (exp_ck + int'({stim[2*i+1], stim[2*i]})) % 65536;
        end
        exp_lat = exp_err ? 1 : 3 * int'(count) + 1;

        wr_q.delete();
        start      = 1'b1;
        base_addr  = base;
        word_count = count;
        c0         = cyc;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = 8'($urandom);
        word_count = 8'($urandom);
        chk({name, ":busy_rise"}, {31'd0, busy}, 32'd1);
        pc0 = pc;

        for (int i = 0; i < n_bytes; i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) gap_cycle(name);
            send_byte(stim[i], name);
            if (restart && i == 0) begin
                start      = 1'b1;
                base_addr  = 8'($urandom_range(0, 127) * 2);
                word_count = 8'($urandom_range(1, 4));
                @(posedge clk); #1;
                start      = 1'b0;
            end
        end

        t = 0;
        while (done !== 1'b1 && err !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end

        chk({name, ":done"}, {31'd0, done}, {31'd0, !exp_err});
        chk({name, ":err"},  {31'd0, err},  {31'd0, exp_err});
        if (gap_mode == 0 && !restart)
            chk({name, ":latency"}, 32'(cyc - c0), 32'(exp_lat));
        chk({name, ":busy_last"}, {31'd0, busy}, 32'd1);
        chk({name, ":ready_low_end"}, {31'd0, in_ready}, 32'd0);
        chk({name, ":pc_held"}, {24'd0, pc}, {24'd0, pc0});
        if (!exp_err) chk({name, ":checksum"}, {16'd0, checksum}, 32'(exp_ck));

        @(posedge clk); #1;
        chk({name, ":busy_fall"}, {31'd0, busy}, 32'd0);
        chk({name, ":pulse_clear"}, {30'd0, done, err}, 32'd0);
        if (!exp_err) chk({name, ":checksum_hold"}, {16'd0, checksum}, 32'(exp_ck));

        chk({name, ":wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk({name, ":wr"}, {8'd0, wr_q[i]}, {8'd0, exp_q[i]});
        stim.delete();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = 8'h00;
        word_count = 8'h00;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // two words back-to-back from 0x00
        stim = '{8'h34, 8'h12, 8'h78, 8'h56};
        run_load(8'h00, 8'd2, 0, 1'b0, "basic");

        // stalled stream: idle cycle before each byte
        stim = '{8'hAA, 8'hBB};
        run_load(8'h10, 8'd1, 1, 1'b0, "toggle");

        run_load(8'h03, 8'd1, 0, 1'b0, "misaligned");

        stim = '{8'hEF, 8'hBE};
        run_load(8'hFE, 8'd1, 0, 1'b0, "last_word");

        run_load(8'hFE, 8'd2, 0, 1'b0, "wrap");

        run_load(8'h40, 8'd0, 0, 1'b0, "zero_count");

        run_load(8'h00, 8'd128, 0, 1'b0, "full_image");

        run_load(8'h02, 8'd128, 0, 1'b0, "one_too_many");

        // second start during a load must not disturb it
        run_load(8'h30, 8'd3, 0, 1'b1, "restart_ignored");

        // reset after one word written and the next low byte taken
        wr_q.delete();
        start      = 1'b1;
        base_addr  = 8'h20;
        word_count = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'h11, "midrst");
        send_byte(8'h22, "midrst");
        send_byte(8'h33, "midrst");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs("midrst");
        in_valid = 1'b1;
        in_data  = 8'h44;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst:ready_idle", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        chk("midrst:wr_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) chk("midrst:wr", {8'd0, wr_q[0]}, {8'd0, 8'h20, 16'h2211});

        run_load(8'h00, 8'd2, 0, 1'b0, "after_rst");

        // random loads, including occasional misaligned or oversized ones
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            logic [7:0] n;
            int         lim;
            b   = 8'($urandom_range(0, 127) * 2);
            if ($urandom_range(0, 7) == 0) b = b | 8'h01;
            lim = (256 - int'(b)) / 2;
            n   = 8'($urandom_range(0, (lim < 6) ? lim + 1 : 6));
            run_load(b, n, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
